updown_counter_display: RTL and testbench
=========================================

// Module: updown_counter_display
// PURPOSE
//  Parametrised multi-digit up/down counter driving 7-segment displays.
//  Generalises the single-digit 4-bit counter/display path: N digits, BCD or hex base,
//  wrap or saturate mode, synchronous load, count enable and terminal-count flags.
//  Sits between the board clock/switches and the display pins at the top level.
// PARAMETERS
//  DIGITS          2   number of cascaded digits (1..8)
//  BASE            10  per-digit modulus: 10 (BCD) or 16 (hex); other values illegal
//  WRAP            1   1 = wrap at limits, 0 = saturate at limits
//  SEG_ACTIVE_LOW  0   1 = invert all segment outputs (common-anode panels)
// PORTS
//  clock       in   1           rising-edge clock
//  n_reset     in   1           asynchronous, active-low reset
//  enable      in   1           count one step this cycle when high
//  down        in   1           direction: 0 = up, 1 = down
//  load        in   1           synchronous load of load_value (priority over enable)
//  load_value  in   4*DIGITS    digit i in bits [4i+3:4i]
//  count       out  4*DIGITS    registered count, digit 0 = least significant
//  display     out  7*DIGITS    digit i segments in [7i+6:7i], bit order a..g = 0..6
//  terminal    out  1           registered 1-cycle pulse: limit crossed/reached on a step
//  at_max      out  1           comb: every digit == BASE-1
//  at_min      out  1           comb: every digit == 0
// BEHAVIOUR
//  - Reset (n_reset low, async): count = 0, terminal = 0; display shows all zeros
//    (segment pattern for "0"), at_min = 1, at_max = 0. Deassertion sync'd by caller.
//  - Per rising edge, priority: load > enable > hold.
//  - load: count <= load_value; any digit >= BASE clamped to BASE-1; terminal <= 0.
//  - enable & !down: digit 0 increments; digit i carries when all lower digits == BASE-1.
//    At at_max: WRAP=1 -> count <= 0, terminal <= 1; WRAP=0 -> hold, terminal <= 1.
//  - enable & down: mirror; borrow when all lower digits == 0.
//    At at_min: WRAP=1 -> all digits BASE-1, terminal <= 1; WRAP=0 -> hold, terminal <= 1.
//  - Otherwise terminal <= 0 (pulse lasts exactly one cycle per limit step).
//  - Latency: count/terminal update 1 cycle after inputs; display, at_max, at_min purely
//    combinational from count (no extra register).
//  - down may change every cycle; direction applies to the edge it is sampled on.
//  - load and enable together: load wins, no step, no terminal.
//  - Segment table (active-high, gfedcba): 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07
//    8=7F 9=6F A=77 b=7C C=39 d=5E E=79 F=71; inverted when SEG_ACTIVE_LOW=1.
//  - BASE=10 never presents digit codes A..F on count.
// STRUCTURE
//  - Shared package: segment-pattern constants (SEG_0..SEG_F), BASE legality check.
//  - One sub-module: seg7_decoder (4-bit digit -> 7 segments), instantiated DIGITS times
//    via generate. Counter/carry chain stays in this module.
// TESTING
//  1 Reset: assert n_reset=0 mid-count (count=37) -> count=00, display=3F_3F, at_min=1 at once.
//  2 BCD up, DIGITS=2, WRAP=1: enable from 98 -> 99 (at_max=1) -> 00 with terminal=1 for 1 cycle.
//  3 BCD down saturate, WRAP=0: from 01, down=1 enable 3 cycles -> 00,00,00; terminal high
//    on cycles 2 and 3, at_min=1.
//  4 Load clamp, BASE=10: load_value=8'hC5 -> count=95; load+enable same cycle -> no step.
//  5 Hex wrap down, BASE=16, DIGITS=2: from 00 step down -> FF, terminal=1, display=71_71.
//  6 Active-low panel, SEG_ACTIVE_LOW=1: count=08 -> display = ~3F,~7F per digit = 40_00.

Source files
------------

// File: rtl/updown_counter_display_pkg.sv
// Shared definitions for the up/down counter display block.
//   - Digit and segment field widths.
//   - Active-high 7-segment patterns SEG_0..SEG_F.
//     Bit order is a..g = bits 0..6, so each value reads as gfedcba.
//   - seg_pattern(): maps a 4-bit digit to its active-high pattern.
//   - base_legal(): accepts only the supported per-digit moduli, 10 and 16.
package updown_counter_display_pkg;

  localparam int DIGIT_W = 4;
  localparam int SEG_W   = 7;

  localparam logic [SEG_W-1:0] SEG_0 = 7'h3F;
  localparam logic [SEG_W-1:0] SEG_1 = 7'h06;
  localparam logic [SEG_W-1:0] SEG_2 = 7'h5B;
  localparam logic [SEG_W-1:0] SEG_3 = 7'h4F;
  localparam logic [SEG_W-1:0] SEG_4 = 7'h66;
  localparam logic [SEG_W-1:0] SEG_5 = 7'h6D;
  localparam logic [SEG_W-1:0] SEG_6 = 7'h7D;
  localparam logic [SEG_W-1:0] SEG_7 = 7'h07;
  localparam logic [SEG_W-1:0] SEG_8 = 7'h7F;
  localparam logic [SEG_W-1:0] SEG_9 = 7'h6F;
  localparam logic [SEG_W-1:0] SEG_A = 7'h77;
  localparam logic [SEG_W-1:0] SEG_B = 7'h7C;
  localparam logic [SEG_W-1:0] SEG_C = 7'h39;
  localparam logic [SEG_W-1:0] SEG_D = 7'h5E;
  localparam logic [SEG_W-1:0] SEG_E = 7'h79;
  localparam logic [SEG_W-1:0] SEG_F = 7'h71;

  function automatic logic [SEG_W-1:0] seg_pattern(input logic [DIGIT_W-1:0] d);
    case (d)
      4'h0:    return SEG_0;
      4'h1:    return SEG_1;
      4'h2:    return SEG_2;
      4'h3:    return SEG_3;
      4'h4:    return SEG_4;
      4'h5:    return SEG_5;
      4'h6:    return SEG_6;
      4'h7:    return SEG_7;
      4'h8:    return SEG_8;
      4'h9:    return SEG_9;
      4'hA:    return SEG_A;
      4'hB:    return SEG_B;
      4'hC:    return SEG_C;
      4'hD:    return SEG_D;
      4'hE:    return SEG_E;
      default: return SEG_F;
    endcase
  endfunction

  function automatic bit base_legal(input int b);
    return (b == 10) || (b == 16);
  endfunction

endpackage

// File: rtl/updown_counter_display_seg7_decoder.sv
// seg7_decoder: converts one 4-bit digit into 7 segment drive lines.
//   digit     in   4   digit value 0..F
//   segments  out  7   a..g on bits 0..6
// When SEG_ACTIVE_LOW is set, all segment lines are inverted for
// common-anode panels.
module seg7_decoder
  import updown_counter_display_pkg::*;
#(
  parameter int SEG_ACTIVE_LOW = 0
) (
  input  logic [DIGIT_W-1:0] digit,
  output logic [SEG_W-1:0]   segments
);

  logic [SEG_W-1:0] pattern;

  assign pattern  = seg_pattern(digit);
  assign segments = (SEG_ACTIVE_LOW != 0) ? ~pattern : pattern;

endmodule

// File: rtl/updown_counter_display.sv
// updown_counter_display: multi-digit BCD/hex up/down counter driving 7-segment displays.
//
// Ports
//   clock       in   1          rising-edge clock
//   n_reset     in   1          asynchronous active-low reset; the caller synchronises release
//   enable      in   1          take one count step this cycle
//   down        in   1          step direction: 0 = up, 1 = down
//   load        in   1          synchronous load of load_value; overrides enable
//   load_value  in   4*DIGITS   digit i in bits [4i+3:4i]
//   count       out  4*DIGITS   registered count; digit 0 is least significant
//   display     out  7*DIGITS   segments for digit i in [7i+6:7i]
//   terminal    out  1          one-cycle pulse after a step taken at a limit
//   at_max      out  1          every digit equals BASE-1
//   at_min      out  1          every digit equals 0
//
// Parameters
//   DIGITS          number of cascaded digits, 1..8
//   BASE            per-digit modulus, 10 or 16
//   WRAP            1 = wrap around at the limits, 0 = saturate at the limits
//   SEG_ACTIVE_LOW  1 = invert every segment output
//
// Timing: count and terminal are registered. display, at_max and at_min are
// decoded combinationally from count, with no extra register.
module updown_counter_display
  import updown_counter_display_pkg::*;
#(
  parameter int DIGITS         = 2,
  parameter int BASE           = 10,
  parameter int WRAP           = 1,
  parameter int SEG_ACTIVE_LOW = 0
) (
  input  logic                    clock,
  input  logic                    n_reset,
  input  logic                    enable,
  input  logic                    down,
  input  logic                    load,
  input  logic [4*DIGITS-1:0]     load_value,
  output logic [4*DIGITS-1:0]     count,
  output logic [7*DIGITS-1:0]     display,
  output logic                    terminal,
  output logic                    at_max,
  output logic                    at_min
);

  localparam logic [DIGIT_W-1:0] DIGIT_MAX = DIGIT_W'(BASE - 1);

  if (!base_legal(BASE)) begin : g_bad_base
    $error("updown_counter_display: BASE must be 10 or 16");
  end
  if (DIGITS < 1 || DIGITS > 8) begin : g_bad_digits
    $error("updown_counter_display: DIGITS must be 1..8");
  end

  // carry[i]  : every digit below i is at DIGIT_MAX, so digit i advances on an up step.
  // borrow[i] : every digit below i is 0, so digit i retreats on a down step.
  // The final entries of each chain double as the whole-count limit flags.
  logic [DIGITS:0]         carry;
  logic [DIGITS:0]         borrow;
  logic [4*DIGITS-1:0]     count_up;
  logic [4*DIGITS-1:0]     count_dn;
  logic [4*DIGITS-1:0]     load_clamped;
  logic [4*DIGITS-1:0]     count_next;
  logic                    terminal_next;

  always_comb begin
    carry        = '0;
    borrow       = '0;
    carry[0]     = 1'b1;
    borrow[0]    = 1'b1;
    count_up     = count;
    count_dn     = count;
    load_clamped = '0;
    for (int i = 0; i < DIGITS; i++) begin
      carry[i+1]  = carry[i]  & (count[4*i +: 4] == DIGIT_MAX);
      borrow[i+1] = borrow[i] & (count[4*i +: 4] == 4'd0);
      if (carry[i]) begin
        count_up[4*i +: 4] = (count[4*i +: 4] == DIGIT_MAX) ? 4'd0
                                                            : count[4*i +: 4] + 4'd1;
      end
      if (borrow[i]) begin
        count_dn[4*i +: 4] = (count[4*i +: 4] == 4'd0) ? DIGIT_MAX
                                                       : count[4*i +: 4] - 4'd1;
      end
      // Out-of-range load digits (A..F in BCD) are clamped so that count never
      // holds a code the base cannot represent.
      load_clamped[4*i +: 4] = (load_value[4*i +: 4] > DIGIT_MAX) ? DIGIT_MAX
                                                                  : load_value[4*i +: 4];
    end
  end

  assign at_max = carry[DIGITS];
  assign at_min = borrow[DIGITS];

  // At a limit, count_up and count_dn already hold the wrapped value,
  // so saturation only needs to select the current count instead.
  always_comb begin
    count_next    = count;
    terminal_next = 1'b0;
    if (load) begin
      count_next = load_clamped;
    end else if (enable && !down) begin
      count_next    = (at_max && WRAP == 0) ? count : count_up;
      terminal_next = at_max;
    end else if (enable && down) begin
      count_next    = (at_min && WRAP == 0) ? count : count_dn;
      terminal_next = at_min;
    end
  end

  // ---- register stage: count and terminal ----
  always_ff @(posedge clock or negedge n_reset) begin
    if (!n_reset) begin
      count    <= '0;
      terminal <= 1'b0;
    end else begin
      count    <= count_next;
      terminal <= terminal_next;
    end
  end

  // ---- combinational display decode ----
  for (genvar g = 0; g < DIGITS; g++) begin : g_digit
    seg7_decoder #(
      .SEG_ACTIVE_LOW(SEG_ACTIVE_LOW)
    ) u_dec (
      .digit   (count[4*g +: 4]),
      .segments(display[7*g +: 7])
    );
  end

endmodule

// File: tb/tb_updown_counter_display.sv
module tb_updown_counter_display;

  logic       clock;
  logic       n_reset;
  logic       enable;
  logic       down;
  logic       load;
  logic [7:0] load_value;

  // a: BCD wrap, s: BCD saturate, h: hex wrap, l: BCD wrap on an active-low panel
  logic [7:0]  count_a, count_s, count_h, count_l;
  logic [13:0] display_a, display_s, display_h, display_l;
  logic        term_a, term_s, term_h, term_l;
  logic        max_a, max_s, max_h, max_l;
  logic        min_a, min_s, min_h, min_l;

  int n_cmp = 0;
  int n_bad = 0;

  updown_counter_display #(.DIGITS(2), .BASE(10), .WRAP(1), .SEG_ACTIVE_LOW(0)) dut_a (
    .clock(clock), .n_reset(n_reset), .enable(enable), .down(down), .load(load),
    .load_value(load_value), .count(count_a), .display(display_a), .terminal(term_a),
    .at_max(max_a), .at_min(min_a));
  updown_counter_display #(.DIGITS(2), .BASE(10), .WRAP(0), .SEG_ACTIVE_LOW(0)) dut_s (
    .clock(clock), .n_reset(n_reset), .enable(enable), .down(down), .load(load),
    .load_value(load_value), .count(count_s), .display(display_s), .terminal(term_s),
    .at_max(max_s), .at_min(min_s));
  updown_counter_display #(.DIGITS(2), .BASE(16), .WRAP(1), .SEG_ACTIVE_LOW(0)) dut_h (
    .clock(clock), .n_reset(n_reset), .enable(enable), .down(down), .load(load),
    .load_value(load_value), .count(count_h), .display(display_h), .terminal(term_h),
    .at_max(max_h), .at_min(min_h));
  updown_counter_display #(.DIGITS(2), .BASE(10), .WRAP(1), .SEG_ACTIVE_LOW(1)) dut_l (
    .clock(clock), .n_reset(n_reset), .enable(enable), .down(down), .load(load),
    .load_value(load_value), .count(count_l), .display(display_l), .terminal(term_l),
    .at_max(max_l), .at_min(min_l));

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_load(input logic [7:0] v);
    load = 1'b1; enable = 1'b0; load_value = v;
    step();
    load = 1'b0;
  endtask

  task automatic test_reset();
    n_reset = 1'b0; enable = 1'b0; down = 1'b0; load = 1'b0; load_value = 8'h00;
    #3;
    n_cmp++; if (count_a !== 8'h00) begin n_bad++; $display("FAIL reset_count got=%h want=00", count_a); end
    n_cmp++; if (display_a !== {7'h3F, 7'h3F}) begin n_bad++; $display("FAIL reset_display got=%h want=%h", display_a, {7'h3F, 7'h3F}); end
    n_cmp++; if (min_a !== 1'b1 || max_a !== 1'b0 || term_a !== 1'b0) begin n_bad++; $display("FAIL reset_flags got min=%b max=%b term=%b want 1 0 0", min_a, max_a, term_a); end
    step();
    n_reset = 1'b1;
    // reach 37 by counting up from a load, then reset asynchronously mid-cycle
    do_load(8'h36);
    enable = 1'b1;
    step();
    enable = 1'b0;
    n_cmp++; if (count_a !== 8'h37) begin n_bad++; $display("FAIL pre_reset_count got=%h want=37", count_a); end
    #2;
    n_reset = 1'b0;
    #1;
    n_cmp++; if (count_a !== 8'h00) begin n_bad++; $display("FAIL async_reset_count got=%h want=00", count_a); end
    n_cmp++; if (display_a !== {7'h3F, 7'h3F}) begin n_bad++; $display("FAIL async_reset_display got=%h want=%h", display_a, {7'h3F, 7'h3F}); end
    n_cmp++; if (min_a !== 1'b1) begin n_bad++; $display("FAIL async_reset_at_min got=%b want=1", min_a); end
    step();
    n_reset = 1'b1;
  endtask

  task automatic test_bcd_up_wrap();
    do_load(8'h09);
    enable = 1'b1; down = 1'b0;
    step();
    n_cmp++; if (count_a !== 8'h10) begin n_bad++; $display("FAIL bcd_carry got=%h want=10", count_a); end
    enable = 1'b0;
    do_load(8'h98);
    enable = 1'b1;
    step();
    n_cmp++; if (count_a !== 8'h99 || max_a !== 1'b1 || term_a !== 1'b0) begin n_bad++; $display("FAIL bcd_up_99 got=%h max=%b term=%b want 99 1 0", count_a, max_a, term_a); end
    n_cmp++; if (display_a !== {7'h6F, 7'h6F}) begin n_bad++; $display("FAIL bcd_up_99_display got=%h want=%h", display_a, {7'h6F, 7'h6F}); end
    step();
    n_cmp++; if (count_a !== 8'h00 || term_a !== 1'b1) begin n_bad++; $display("FAIL bcd_up_wrap got=%h term=%b want 00 1", count_a, term_a); end
    enable = 1'b0;
    step();
    n_cmp++; if (count_a !== 8'h00 || term_a !== 1'b0) begin n_bad++; $display("FAIL bcd_up_term_pulse got=%h term=%b want 00 0", count_a, term_a); end
  endtask

  task automatic test_bcd_down_saturate();
    do_load(8'h01);
    enable = 1'b1; down = 1'b1;
    step();
    n_cmp++; if (count_s !== 8'h00 || term_s !== 1'b0) begin n_bad++; $display("FAIL sat_down_c1 got=%h term=%b want 00 0", count_s, term_s); end
    step();
    n_cmp++; if (count_s !== 8'h00 || term_s !== 1'b1) begin n_bad++; $display("FAIL sat_down_c2 got=%h term=%b want 00 1", count_s, term_s); end
    step();
    n_cmp++; if (count_s !== 8'h00 || term_s !== 1'b1 || min_s !== 1'b1) begin n_bad++; $display("FAIL sat_down_c3 got=%h term=%b min=%b want 00 1 1", count_s, term_s, min_s); end
    enable = 1'b0; down = 1'b0;
    step();
    n_cmp++; if (term_s !== 1'b0) begin n_bad++; $display("FAIL sat_down_term_clear got=%b want=0", term_s); end
    do_load(8'h99);
    enable = 1'b1;
    step();
    n_cmp++; if (count_s !== 8'h99 || term_s !== 1'b1) begin n_bad++; $display("FAIL sat_up_hold got=%h term=%b want 99 1", count_s, term_s); end
    enable = 1'b0;
  endtask

  task automatic test_load_clamp();
    do_load(8'hC5);
    n_cmp++; if (count_a !== 8'h95) begin n_bad++; $display("FAIL load_clamp_hi got=%h want=95", count_a); end
    do_load(8'h3F);
    n_cmp++; if (count_a !== 8'h39) begin n_bad++; $display("FAIL load_clamp_lo got=%h want=39", count_a); end
    load = 1'b1; enable = 1'b1; down = 1'b0; load_value = 8'h42;
    step();
    load = 1'b0; enable = 1'b0;
    n_cmp++; if (count_a !== 8'h42 || term_a !== 1'b0) begin n_bad++; $display("FAIL load_over_enable got=%h term=%b want 42 0", count_a, term_a); end
    do_load(8'h99);
    load = 1'b1; enable = 1'b1; load_value = 8'h99;
    step();
    load = 1'b0; enable = 1'b0;
    n_cmp++; if (count_a !== 8'h99 || term_a !== 1'b0) begin n_bad++; $display("FAIL load_at_max_no_term got=%h term=%b want 99 0", count_a, term_a); end
  endtask

  task automatic test_hex_down_wrap();
    do_load(8'h00);
    enable = 1'b1; down = 1'b1;
    step();
    n_cmp++; if (count_h !== 8'hFF || term_h !== 1'b1 || max_h !== 1'b1) begin n_bad++; $display("FAIL hex_down_wrap got=%h term=%b max=%b want ff 1 1", count_h, term_h, max_h); end
    n_cmp++; if (display_h !== {7'h71, 7'h71}) begin n_bad++; $display("FAIL hex_down_display got=%h want=%h", display_h, {7'h71, 7'h71}); end
    enable = 1'b0; down = 1'b0;
    do_load(8'h0F);
    enable = 1'b1;
    step();
    enable = 1'b0;
    n_cmp++; if (count_h !== 8'h10 || term_h !== 1'b0) begin n_bad++; $display("FAIL hex_carry got=%h term=%b want 10 0", count_h, term_h); end
    do_load(8'hAB);
    n_cmp++; if (count_h !== 8'hAB || display_h !== {7'h77, 7'h7C}) begin n_bad++; $display("FAIL hex_load_ab got=%h disp=%h want ab %h", count_h, display_h, {7'h77, 7'h7C}); end
  endtask

  task automatic test_active_low();
    do_load(8'h08);
    n_cmp++; if (display_l !== {7'h40, 7'h00}) begin n_bad++; $display("FAIL active_low_08 got=%h want=%h", display_l, {7'h40, 7'h00}); end
    do_load(8'h21);
    n_cmp++; if (display_l !== {7'h24, 7'h79}) begin n_bad++; $display("FAIL active_low_21 got=%h want=%h", display_l, {7'h24, 7'h79}); end
  endtask

  task automatic test_back_to_back();
    do_load(8'h50);
    enable = 1'b1; down = 1'b0;
    step();
    n_cmp++; if (count_a !== 8'h51) begin n_bad++; $display("FAIL b2b_up got=%h want=51", count_a); end
    down = 1'b1;
    step();
    n_cmp++; if (count_a !== 8'h50) begin n_bad++; $display("FAIL b2b_down1 got=%h want=50", count_a); end
    step();
    n_cmp++; if (count_a !== 8'h49) begin n_bad++; $display("FAIL b2b_borrow got=%h want=49", count_a); end
    down = 1'b0;
    step();
    n_cmp++; if (count_a !== 8'h50) begin n_bad++; $display("FAIL b2b_up_carry got=%h want=50", count_a); end
    enable = 1'b0;
    do_load(8'h00);
    enable = 1'b1; down = 1'b1;
    step();
    n_cmp++; if (count_a !== 8'h99 || term_a !== 1'b1) begin n_bad++; $display("FAIL bcd_down_wrap got=%h term=%b want 99 1", count_a, term_a); end
    step();
    n_cmp++; if (count_a !== 8'h98 || term_a !== 1'b0) begin n_bad++; $display("FAIL bcd_down_after_wrap got=%h term=%b want 98 0", count_a, term_a); end
    enable = 1'b0; down = 1'b0;
    step();
    n_cmp++; if (count_a !== 8'h98) begin n_bad++; $display("FAIL hold got=%h want=98", count_a); end
  endtask

  initial begin
    test_reset();
    test_bcd_up_wrap();
    test_bcd_down_saturate();
    test_load_clamp();
    test_hex_down_wrap();
    test_active_low();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
